// File: rtl/code_8_3.sv
// code_8_3: registered 8-to-3 priority encoder with valid and multi-hot flags.
// Winner selection is built from one small grant lane per request bit; the
// lanes are independent, so the encoder is a flat OR tree with no ripple chain.

// Grant lane: request IDX wins when it is set and no higher-priority bit is set.
module code_8_3_lane #(
  parameter int LSB_PRIORITY = 0,
  parameter int IDX          = 0
) (
  input  logic [7:0] din,
  output logic       grant
);
  localparam logic [7:0] ONE   = 8'd1;
  localparam logic [7:0] SELF  = ONE << IDX;
  localparam logic [7:0] BELOW = SELF - ONE;
  localparam logic [7:0] ABOVE = ~(BELOW | SELF);
  // Bits that outrank this lane: lower indices when LSB wins, higher otherwise.
  localparam logic [7:0] BLOCK = (LSB_PRIORITY != 0) ? BELOW : ABOVE;

  // Grant only when nothing of higher priority is requesting.
  always_comb begin
    grant = din[IDX] & ~|(din & BLOCK);
  end
endmodule

module code_8_3 #(
  parameter int LSB_PRIORITY = 0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic [7:0] din,
  output logic [2:0] dout,
  output logic       valid,
  output logic       multi
);
  localparam int NUM_LANES = 8;
  localparam int IDX_W     = 3;

  typedef struct packed {
    logic [IDX_W-1:0] idx;
    logic             valid;
    logic             multi;
  } enc_t;

  logic [NUM_LANES-1:0] grant;
  enc_t                 enc_d;
  enc_t                 enc_q;

  // One grant lane per request bit; at most one lane can be high.
  genvar g;
  generate
    for (g = 0; g < NUM_LANES; g++) begin : g_lane
      code_8_3_lane #(
        .LSB_PRIORITY (LSB_PRIORITY),
        .IDX          (g)
      ) u_lane (
        .din   (din),
        .grant (grant[g])
      );
    end
  endgenerate

  // Encode the one-hot grant to binary; an idle vector yields index 0.
  always_comb begin
    enc_d.idx = '0;
    for (int i = 0; i < NUM_LANES; i++) begin
      if (grant[i]) enc_d.idx = enc_d.idx | IDX_W'(i);
    end
  end

  // Saturating population count: track "seen one" and "seen two or more".
  always_comb begin
    logic seen_one;
    logic seen_two;
    seen_one = 1'b0;
    seen_two = 1'b0;
    for (int i = 0; i < NUM_LANES; i++) begin
      seen_two = seen_two | (seen_one & din[i]);
      seen_one = seen_one | din[i];
    end
    enc_d.valid = seen_one;
    enc_d.multi = seen_two;
  end

  // Output register: capture on en, hold otherwise, clear asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      enc_q <= '0;
    end else if (en) begin
      enc_q <= enc_d;
    end
  end

  assign dout  = enc_q.idx;
  assign valid = enc_q.valid;
  assign multi = enc_q.multi;
endmodule

// File: tb/tb_code_8_3.sv
// Scoreboard bench for code_8_3: both priority settings run side by side.
// Stimulus pushes the expected registered outputs; a monitor pops and checks
// them one cycle after each driven edge.
module tb_code_8_3;
  logic       clk;
  logic       rst_n;
  logic       en;
  logic [7:0] din;
  logic [2:0] dout0, dout1;
  logic       valid0, valid1, multi0, multi1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [2:0] d0;
    logic       v0;
    logic       m0;
    logic [2:0] d1;
    logic       v1;
    logic       m1;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  exp_t mon_x;

  code_8_3 #(.LSB_PRIORITY(0)) u_msb (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .dout(dout0), .valid(valid0), .multi(multi0)
  );

  code_8_3 #(.LSB_PRIORITY(1)) u_lsb (
    .clk(clk), .rst_n(rst_n), .en(en), .din(din),
    .dout(dout1), .valid(valid1), .multi(multi1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: scan bits directly, no priority masks.
  function automatic exp_t model(input logic [7:0] d);
    exp_t r;
    int   cnt;
    cnt  = 0;
    r.d0 = 3'd0;
    r.d1 = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (d[i]) begin
        cnt++;
        r.d0 = 3'(i);
      end
    end
    for (int i = 7; i >= 0; i--) begin
      if (d[i]) r.d1 = 3'(i);
    end
    r.v0 = (cnt > 0);
    r.v1 = (cnt > 0);
    r.m0 = (cnt > 1);
    r.m1 = (cnt > 1);
    return r;
  endfunction

  task automatic step(input logic e, input logic [7:0] d);
    @(negedge clk);
    en  = e;
    din = d;
    if (e) cur = model(d);
    sb.push_back(cur);
  endtask

  task automatic chk_now(input string tag, input int d0, input int v, input int m, input int d1);
    chk({tag, "_dout0"}, int'(dout0), d0);
    chk({tag, "_valid0"}, int'(valid0), v);
    chk({tag, "_multi0"}, int'(multi0), m);
    chk({tag, "_dout1"}, int'(dout1), d1);
    chk({tag, "_valid1"}, int'(valid1), v);
    chk({tag, "_multi1"}, int'(multi1), m);
  endtask

  // Monitor: one expected entry per driven edge, compared after the edge.
  always @(posedge clk) begin
    #1;
    if (sb.size() > 0) begin
      mon_x = sb.pop_front();
      chk("sb_dout0",  int'(dout0),  int'(mon_x.d0));
      chk("sb_valid0", int'(valid0), int'(mon_x.v0));
      chk("sb_multi0", int'(multi0), int'(mon_x.m0));
      chk("sb_dout1",  int'(dout1),  int'(mon_x.d1));
      chk("sb_valid1", int'(valid1), int'(mon_x.v1));
      chk("sb_multi1", int'(multi1), int'(mon_x.m1));
    end
  end

  logic [7:0] vec;
  int         budget;

  initial begin
    rst_n = 1'b0;
    en    = 1'b1;
    din   = 8'hFF;
    cur   = '{default: '0};
    // Reset holds outputs at zero even with en=1 and a full request vector.
    repeat (2) @(posedge clk);
    #2;
    chk_now("reset", 0, 0, 0, 0);
    @(negedge clk);
    rst_n = 1'b1;
    en    = 1'b0;

    // One-hot sweep.
    for (int i = 0; i < 8; i++) begin
      vec = 8'd1 << i;
      step(1'b1, vec);
    end
    // Priority check: 1001_0110 -> 7 (MSB) / 1 (LSB), multi.
    step(1'b1, 8'b1001_0110);
    cur = '{d0: 3'd7, v0: 1'b1, m0: 1'b1, d1: 3'd1, v1: 1'b1, m1: 1'b1};
    sb[sb.size()-1] = cur;
    // Zero after 8'h40.
    step(1'b1, 8'h40);
    step(1'b1, 8'h00);
    // Hold: capture 8'h08, then en=0 with 8'h80 for three edges.
    step(1'b1, 8'h08);
    repeat (3) step(1'b0, 8'h80);

    // Async reset with dout=5 held.
    step(1'b1, 8'h20);
    step(1'b0, 8'h01);
    @(posedge clk);
    #2;
    chk_now("held5", 5, 1, 0, 5);
    #1;
    rst_n = 1'b0;
    #1;
    chk_now("async_rst", 0, 0, 0, 0);
    cur = '{default: '0};
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 8'h04);
    cur = '{d0: 3'd2, v0: 1'b1, m0: 1'b0, d1: 3'd2, v1: 1'b1, m1: 1'b0};
    sb[sb.size()-1] = cur;

    // Exhaustive sweep against the model.
    for (int v = 0; v < 256; v++) begin
      step(1'b1, 8'(v));
    end

    // Drain the scoreboard within a bounded number of cycles.
    budget = 0;
    while (sb.size() > 0 && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    chk("sb_drained", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
